// File: rtl/cpu_pio_pkg.sv
// cpu_pio_pkg: constants and poll FSM encoding shared by the button poller files
package cpu_pio_pkg;
    localparam int         AVM_DATA_W      = 32;
    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CAPTURE} poll_state_t;
endpackage

// File: rtl/cpu_debounce_vec.sv
// cpu_debounce_vec: whole-vector debouncer with press/release edge outputs
//   clk, reset : clock and synchronous active-high reset
//   i_valid    : strobe qualifying i_sample
//   i_sample   : normalised sample, 1 = pressed
//   o_stable   : debounced state
//   o_rise     : bits that become pressed this cycle
//   o_fall     : bits that become released this cycle
module cpu_debounce_vec
    import cpu_pio_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_sample,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);
    localparam int            CW   = $clog2(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CNT - 1);

    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;
    logic             w_same;
    logic             w_settle;
    logic [CW-1:0]    w_cnt_n;
    logic [WIDTH-1:0] w_stable_n;

    assign w_same     = i_sample == r_cand;
    assign w_cnt_n    = !w_same ? '0 : (r_cnt == CMAX) ? CMAX : r_cnt + 1'b1;
    // a saturated count implies i_sample equals the candidate, so it can be used directly
    assign w_settle   = i_valid && (w_cnt_n == CMAX) && (i_sample != r_stable);
    assign w_stable_n = w_settle ? i_sample : r_stable;
    assign o_rise     = w_stable_n & ~r_stable;
    assign o_fall     = ~w_stable_n & r_stable;
    assign o_stable   = r_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (i_valid) begin
            r_cand   <= i_sample;
            r_cnt    <= w_cnt_n;
            r_stable <= w_stable_n;
        end
    end
endmodule

// File: rtl/cpu_buttons_poller.sv
// cpu_buttons_poller: polls the button PIO over Avalon-MM and reports debounced edges
//   clk, reset                     : clock and synchronous active-high reset
//   avm_address/avm_read           : read initiator towards the PIO data register
//   avm_readdata                   : slave data, valid the cycle after the strobe
//   buttons_stable                 : debounced state, 1 = pressed
//   event_valid/event_ready        : handshake for pending edges
//   event_press/event_release      : sticky pending edges
module cpu_buttons_poller
    import cpu_pio_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    output logic [WIDTH-1:0]      buttons_stable,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [WIDTH-1:0]      event_press,
    output logic [WIDTH-1:0]      event_release
);
    localparam int            DW    = $clog2(POLL_DIV);
    // IDLE spans POLL_DIV-2 cycles so READ + CAPTURE complete a POLL_DIV period
    localparam logic [DW-1:0] DLAST = DW'(POLL_DIV - 3);

    poll_state_t      r_state;
    logic [DW-1:0]    r_div;
    logic             r_read;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_release;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             w_capture;
    logic             w_accept;
    logic             w_unused;

    assign avm_address   = PIO_DATA_OFFSET;
    assign avm_read      = r_read;
    assign w_raw         = avm_readdata[WIDTH-1:0];
    assign w_sample      = (ACTIVE_LOW != 0) ? ~w_raw : w_raw;
    assign w_capture     = r_state == ST_CAPTURE;
    assign w_unused      = ^avm_readdata;
    assign event_press   = r_press;
    assign event_release = r_release;
    assign event_valid   = |r_press | |r_release;
    assign w_accept      = event_valid && event_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_read  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_div == DLAST) begin
                        r_div   <= '0;
                        r_read  <= 1'b1;
                        r_state <= ST_READ;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_READ: begin
                    r_read  <= 1'b0;
                    r_state <= ST_CAPTURE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    cpu_debounce_vec #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (w_capture),
        .i_sample (w_sample),
        .o_stable (buttons_stable),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    // an accepted event is dropped but edges born in the same cycle survive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= (w_accept ? '0 : r_press) | w_rise;
            r_release <= (w_accept ? '0 : r_release) | w_fall;
        end
    end
endmodule
